// File: rtl/ps2_kbd_event_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard event receiver.
package ps2_pkg;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_event_t;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Odd parity holds when data bits and parity bit XOR to one.
    function automatic logic ps2_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_kbd_event_rx_fifo.sv
// Generic DEPTH-entry FIFO of keyboard events; push while full is ignored
// unless a pop happens in the same cycle, pop while empty is ignored.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          push,
    input  logic          pop,
    input  kbd_event_t    din,
    output kbd_event_t    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    kbd_event_t    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == {CW{1'b0}});
    assign w_rd  = pop & ~empty;
    assign w_wr  = push & (~full | w_rd);
    assign dout  = r_mem[r_rp];
    assign count = r_count;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wp    <= {AW{1'b0}};
            r_rp    <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= din;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_rd) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_event_rx.sv
// PS/2 device-to-host receiver folding E0/F0 prefixes into buffered key events.
// Optional typematic-repeat suppression is enabled by defining PS2_REPEAT_FILTER_EN.
module ps2_kbd_event_rx
    import ps2_pkg::*;
#(
    parameter  int DEPTH       = 8,
    parameter  int SYNC_STAGES = 2,
    parameter  int TIMEOUT_CYC = 100000,
    parameter  int ERR_CNT_W   = 8,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    input  logic                 nextdata_n,
    output logic [7:0]           data,
    output logic                 ext,
    output logic                 brk,
    output logic                 ready,
    output logic                 overflow,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [CW-1:0]        count
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic                   w_fall;
    logic                   w_dat;

    rx_state_t      r_state;
    rx_state_t      w_state_nxt;
    logic [7:0]     r_shift;
    logic [2:0]     r_bit_idx;
    logic           r_par;
    logic [TW-1:0]  r_timer;
    logic           w_timeout;
    logic           w_byte_vld;
    logic           w_frame_bad;

    logic           r_ext_pend;
    logic           r_brk_pend;
    kbd_event_t     r_evt;
    logic           r_evt_vld;

    logic           r_frame_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic           r_nd_q;
    logic           r_nd_q2;
    logic           r_overflow;

    logic           w_pop_req;
    logic           w_pop_eff;
    logic           w_push_req;
    logic           w_drop;
    logic           w_accept;
    logic           w_rep;
    logic           w_full;
    logic           w_empty;
    kbd_event_t     w_head;

    // Pin synchronisers idle high, matching an idle PS/2 bus.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_sync <= {SYNC_STAGES{1'b1}};
            r_dat_sync <= {SYNC_STAGES{1'b1}};
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_dat     = r_dat_sync[SYNC_STAGES-1];
    assign w_timeout = (r_state != IDLE) & ~w_fall & (r_timer == TW'(TIMEOUT_CYC - 1));

    // Frame FSM: state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame FSM: next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = (w_fall & ~w_dat) ? DATA : IDLE;
                DATA:    w_state_nxt = (w_fall & (r_bit_idx == 3'd7)) ? PARITY : DATA;
                PARITY:  w_state_nxt = w_fall ? STOP : PARITY;
                STOP:    w_state_nxt = w_fall ? IDLE : STOP;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Frame FSM: outputs decided on the stop-bit edge or on timeout.
    always_comb begin
        w_byte_vld  = 1'b0;
        w_frame_bad = w_timeout;
        if ((r_state == STOP) && w_fall) begin
            if (w_dat && ps2_parity_ok(r_shift, r_par)) begin
                w_byte_vld = 1'b1;
            end else begin
                w_frame_bad = 1'b1;
            end
        end else begin
            w_byte_vld = 1'b0;
        end
    end

    // Bit datapath and inter-edge timer.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
            r_par     <= 1'b0;
            r_timer   <= {TW{1'b0}};
        end else begin
            r_timer <= ((r_state == IDLE) || w_fall) ? {TW{1'b0}} : r_timer + TW'(1);
            if (w_fall) begin
                case (r_state)
                    IDLE: begin
                        r_shift   <= 8'h00;
                        r_bit_idx <= 3'd0;
                    end
                    DATA: begin
                        r_shift   <= {w_dat, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    PARITY:  r_par <= w_dat;
                    default: r_par <= r_par;
                endcase
            end
        end
    end

    // Prefix folding: E0/F0 arm flags, any other byte emits one event.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
            r_evt      <= '0;
            r_evt_vld  <= 1'b0;
        end else begin
            r_evt_vld <= 1'b0;
            if (w_byte_vld) begin
                if (r_shift == PS2_PFX_EXT) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == PS2_PFX_BRK) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    r_evt      <= {r_ext_pend, r_brk_pend, r_shift};
                    r_evt_vld  <= 1'b1;
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                end
            end
        end
    end

    // Error pulse and saturating error counter.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_frame_err <= 1'b0;
            r_err_cnt   <= {ERR_CNT_W{1'b0}};
        end else begin
            r_frame_err <= w_frame_bad;
            if (w_frame_bad && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic       r_lm_vld;
    logic [8:0] r_lm;
    logic       w_lm_match;

    assign w_lm_match = (r_lm == {r_evt.ext, r_evt.code});
    assign w_rep      = ~r_evt.brk & r_lm_vld & w_lm_match;

    // Last accepted make code; a matching break re-arms the key.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_lm_vld <= 1'b0;
            r_lm     <= 9'h000;
        end else if (r_evt_vld && r_evt.brk && w_lm_match) begin
            r_lm_vld <= 1'b0;
        end else if (w_accept && !r_evt.brk) begin
            r_lm_vld <= 1'b1;
            r_lm     <= {r_evt.ext, r_evt.code};
        end
    end
`else
    assign w_rep = 1'b0;
`endif

    // nextdata_n is registered once, then edge-detected so a held low pops once.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_nd_q  <= 1'b1;
            r_nd_q2 <= 1'b1;
        end else begin
            r_nd_q  <= nextdata_n;
            r_nd_q2 <= r_nd_q;
        end
    end

    assign w_pop_req  = r_nd_q2 & ~r_nd_q;
    assign w_pop_eff  = w_pop_req & ~w_empty;
    assign w_push_req = r_evt_vld & ~w_rep;
    assign w_drop     = w_push_req & w_full & ~w_pop_eff;
    assign w_accept   = w_push_req & ~w_drop;

    // Sticky overflow, cleared by the next successful pop.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_pop_eff) begin
            r_overflow <= 1'b0;
        end
    end

    ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (w_push_req),
        .pop   (w_pop_eff),
        .din   (r_evt),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (count)
    );

    assign data      = w_empty ? 8'h00 : w_head.code;
    assign ext       = w_empty ? 1'b0  : w_head.ext;
    assign brk       = w_empty ? 1'b0  : w_head.brk;
    assign ready     = ~w_empty;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: doc/ps2_kbd_event_rx.md
Name: ps2_kbd_event_rx

Overview:
- Parametrised successor to the PS/2 keyboard receiver: deserialises PS/2 device-to-host frames and checks start, odd parity and stop bits.
- Folds E0 (extended) and F0 (break) prefixes into one key event per key action.
- Buffers events in a DEPTH-entry FIFO read with the existing active-low nextdata_n strobe.
- Sits between the ps2_clk/ps2_data pins and the keyboard MMIO/CPU side.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- SYNC_STAGES, 2, synchroniser flops on ps2_clk and ps2_data; >= 2.
- TIMEOUT_CYC, 100000, clk cycles without a ps2_clk falling edge before a partial frame is aborted.
- ERR_CNT_W, 8, width of the saturating frame-error counter.

Ports:
- clk  input  1  system clock.
- clrn  input  1  asynchronous active-low reset.
- ps2_clk  input  1  PS/2 clock from device, asynchronous.
- ps2_data  input  1  PS/2 data from device, asynchronous.
- nextdata_n  input  1  active-low read strobe; its 1->0 transition pops one event.
- data  output  8  scan code of the FIFO head event.
- ext  output  1  head event was E0-prefixed.
- brk  output  1  head event is a release (F0-prefixed).
- ready  output  1  FIFO non-empty.
- overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse per rejected or aborted frame.
- err_cnt  output  ERR_CNT_W  saturating count of frame errors.
- count  output  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (clrn=0, asynchronous): FSM IDLE, FIFO empty, prefix flags clear, count=0, ready=0, overflow=0, frame_err=0, err_cnt=0, data/ext/brk=0. Reset mid-frame discards the partial frame.
- Synchronisation: ps2_clk and ps2_data pass through SYNC_STAGES flops. A falling edge is synchronised ps2_clk going prev=1, cur=0. All bit sampling uses synchronised ps2_data on that cycle.
- Frame FSM:
  - IDLE: on a falling edge with data=0, go to DATA with bit index 0. A falling edge with data=1 is ignored, no error.
  - DATA: shift in LSB first; after 8 bits go to PARITY.
  - PARITY: capture the bit, go to STOP.
  - STOP: require stop=1 and odd parity (XOR of the 8 data bits and parity bit = 1). If good, pass the byte to the decoder the same cycle. If bad, pulse frame_err and increment err_cnt, saturating at all-ones. Return to IDLE either way.
  - Timeout: in any non-IDLE state, TIMEOUT_CYC cycles with no falling edge force IDLE, pulse frame_err and increment err_cnt.
- Decoder:
  - Byte E0 sets ext_pend; byte F0 sets brk_pend; neither produces an event.
  - Any other byte forms the event {ext_pend, brk_pend, byte} and clears both flags.
  - Prefix flags survive frame errors and are cleared only by an event or reset.
- FIFO:
  - An event is pushed one cycle after the stop-bit edge; ready rises the following cycle.
  - data/ext/brk show the head entry and are 0 when empty.
  - Pop fires on the cycle after nextdata_n is sampled going 1->0 (nextdata_n is registered once). A pop while empty is ignored. A held-low nextdata_n pops only once.
  - Push while full and no pop in the same cycle: the new event is dropped and overflow is set. overflow clears on the next successful pop or on reset.
  - Simultaneous push and pop when full: both take effect, count unchanged, no overflow.
  - Simultaneous push and pop when empty: push only.
  - Pointers wrap modulo DEPTH.

Optional Feature:
- PS2_REPEAT_FILTER_EN defined:
  - A last_make register holds {ext, code} of the last pushed make event plus a valid bit.
  - A make event equal to last_make is dropped as typematic repeat; it does not touch overflow.
  - A break event of the same {ext, code} clears the valid bit. Reset clears it.
- Undefined: every make event is pushed, repeats included.

Decomposition:
- Package ps2_pkg holds:
  - typedef kbd_event_t as a packed struct {ext, brk, code[7:0]}.
  - Constants PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0.
  - Enum rx_state_t {IDLE, DATA, PARITY, STOP}.
- Sub-module ps2_event_fifo: generic DEPTH x kbd_event_t FIFO with push, pop, full, empty and count. The top module owns the overflow logic.

Test Plan:
- Send 1C, then pulse nextdata_n low 2 cycles -> ready=1, data=1C, ext=0, brk=0, count=1 before the pulse; ready=0, count=0 after it.
- Send F0,1C then E0,75 then E0,F0,75 -> three events: (1C, brk=1); (75, ext=1); (75, ext=1, brk=1).
- Send 1B with flipped parity bit, then a correct 1B -> one frame_err pulse, err_cnt=1, exactly one event 1B.
- DEPTH=8: send 9 codes 01..09 without popping -> count=8, overflow=1, head data=01. One pop -> data=02, overflow=0.
- Send start plus 4 data bits then stop ps2_clk -> frame_err after TIMEOUT_CYC cycles, FSM in IDLE, a following 1C is received correctly. Also assert clrn mid-frame -> no event is produced.
- Send 1B,1B,1B,F0,1B -> with PS2_REPEAT_FILTER_EN: 2 events (make 1B, break 1B); without it: 4 events.
